// File: rtl/exe_sequencer_if.sv
//------------------------------------------------------------------------------
// exe_sequencer_if
// Opcode package and the decode/ALU/memory-stage bundle used by exe_sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package exe_sequencer_pkg;
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_XOR   = 4'd2,
    OP_OR    = 4'd3,
    OP_AND   = 4'd4,
    OP_ADDI  = 4'd5,
    OP_XORI  = 4'd6,
    OP_ORI   = 4'd7,
    OP_ANDI  = 4'd8,
    OP_JAL   = 4'd9,
    OP_JALR  = 4'd10,
    OP_AUIPC = 4'd11,
    OP_LD    = 4'd12,
    OP_SD    = 4'd13,
    OP_MUL   = 4'd14,
    OP_DIV   = 4'd15
  } op_t;
endpackage

interface exe_sequencer_if;
  import exe_sequencer_pkg::*;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  op_t         in_op;
  logic [1:0]  in_cls;
  logic        sel_a_pc;
  logic        sel_b_imm;
  logic        unit_start;
  logic [63:0] alu_res;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res;
  logic        busy;

  // Pipeline side driving the sequencer (decode, ALU result, memory stage).
  modport master (
    output flush, in_valid, in_op, in_cls, alu_res, out_ready,
    input  in_ready, sel_a_pc, sel_b_imm, unit_start, out_valid, out_res, busy
  );

  // The sequencer itself.
  modport slave (
    input  flush, in_valid, in_op, in_cls, alu_res, out_ready,
    output in_ready, sel_a_pc, sel_b_imm, unit_start, out_valid, out_res, busy
  );
endinterface

`default_nettype wire

// File: rtl/exe_sequencer.sv
//------------------------------------------------------------------------------
// exe_sequencer
// Execute-stage controller: accepts decoded ops, drives ALU operand selects,
// times single-cycle and multi-cycle (MUL/DIV) ops, and presents a registered
// result downstream with valid/ready back-pressure.
// Optional macro EXE_SEQ_PERF_EN adds saturating stall_cycles/op_count outputs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module exe_sequencer
  import exe_sequencer_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 64,
  parameter int CNT_W      = 7
) (
  input  wire logic      clk,
  input  wire logic      reset,
  exe_sequencer_if.slave bus
`ifdef EXE_SEQ_PERF_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    op_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter load values: the capture happens on the cycle cnt reaches zero.
  localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [63:0]       r_out_res;
  op_t               r_op;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_multi;
  op_t               w_dec_op;
  logic              w_sel_en;

  function automatic logic dec_pc(input op_t op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_AUIPC);
  endfunction

  function automatic logic dec_imm(input op_t op);
    case (op)
      OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_JAL, OP_JALR,
      OP_AUIPC, OP_LD, OP_SD: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Handshake, class decode and next-state selection; flush overrides everything.
  always_comb begin
    w_in_ready = !bus.flush && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
    w_accept   = bus.in_valid && w_in_ready;
    w_is_mul   = (bus.in_cls == 2'd1);
    w_is_multi = w_is_mul || (bus.in_cls == 2'd2);
    w_next     = r_state;
    case (r_state)
      S_WAIT:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_accept) w_next = w_is_multi ? S_WAIT : S_DONE;
    if (bus.flush) w_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Op latch, cycle counter and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_out_res <= '0;
      r_op      <= OP_ADD;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op <= bus.in_op;
      if (w_is_multi) begin
        r_cnt <= w_is_mul ? C_MUL_LOAD : C_DIV_LOAD;
      end else begin
        r_cnt     <= '0;
        r_out_res <= bus.alu_res;
      end
    end else if (r_state == S_WAIT) begin
      if (r_cnt == '0) r_out_res <= bus.alu_res;
      else             r_cnt     <= r_cnt - 1'b1;
    end
  end

  // Operand selects follow the incoming op on accept, otherwise the held op.
  always_comb begin
    w_dec_op = w_accept ? bus.in_op : r_op;
    w_sel_en = w_accept || (r_state != S_IDLE);
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.unit_start = w_accept && w_is_multi;
  assign bus.sel_a_pc   = w_sel_en && dec_pc(w_dec_op);
  assign bus.sel_b_imm  = w_sel_en && dec_imm(w_dec_op);
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.out_res    = r_out_res;
  assign bus.busy       = (r_state == S_WAIT);

`ifdef EXE_SEQ_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_op_count;

  // Saturating stall and retired-op counters; a flushed-but-accepted result still counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_op_count     <= '0;
    end else begin
      if (((r_state == S_WAIT) || ((r_state == S_DONE) && !bus.out_ready)) && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if ((r_state == S_DONE) && bus.out_ready && (r_op_count != '1))
        r_op_count <= r_op_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign op_count     = r_op_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exe_sequencer.sv
//------------------------------------------------------------------------------
// tb_exe_sequencer
// Randomized bench for exe_sequencer with a transaction-level scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_exe_sequencer;
  import exe_sequencer_pkg::*;

  localparam int MUL_N = 3;
  localparam int DIV_N = 64;

  typedef struct {
    logic [63:0] res;
    int          vcyc;   // cycle index at which the result must be visible
    op_t         op;
    logic [1:0]  cls;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exe_sequencer_if bus();

`ifdef EXE_SEQ_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] op_count;
`endif

  exe_sequencer #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .CNT_W     (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef EXE_SEQ_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .op_count    (op_count)
`endif
  );

  task automatic check1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Result value the ALU/unit presents during a given cycle.
  function automatic logic [63:0] mk(input int c);
    logic [31:0] u;
    u = unsigned'(c);
    return {32'hA11C_E000 ^ u, u * 32'h9E37_79B9};
  endfunction

  function automatic logic ref_pc(input op_t op);
    return op inside {OP_JAL, OP_JALR, OP_AUIPC};
  endfunction

  function automatic logic ref_imm(input op_t op);
    return op inside {OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_JAL, OP_JALR, OP_AUIPC, OP_LD, OP_SD};
  endfunction

  function automatic logic is_multi(input logic [1:0] cls);
    return (cls == 2'd1) || (cls == 2'd2);
  endfunction

  // One cycle of stimulus: drive, check handshake/select outputs, then update the model.
  task automatic drive(input logic v, input op_t op, input logic [1:0] cls,
                       input logic rdy, input logic fl);
    logic exp_rdy, acc, ep, ei, eb;
    int   lat;
    exp_t e;
    @(negedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_cls    = cls;
    bus.out_ready = rdy;
    bus.flush     = fl;
    bus.alu_res   = mk(cyc + 1);
    #1;
    exp_rdy = !fl && ((sb.size() == 0) || ((sb[0].vcyc <= cyc) && rdy));
    acc     = v && exp_rdy;
    if (acc) begin
      ep = ref_pc(op);
      ei = ref_imm(op);
    end else if (sb.size() != 0) begin
      ep = ref_pc(sb[0].op);
      ei = ref_imm(sb[0].op);
    end else begin
      ep = 1'b0;
      ei = 1'b0;
    end
    eb = (sb.size() != 0) && is_multi(sb[0].cls) && (cyc < sb[0].vcyc);
    check1("in_ready",   bus.in_ready,   exp_rdy);
    check1("unit_start", bus.unit_start, acc && is_multi(cls));
    check1("sel_a_pc",   bus.sel_a_pc,   ep);
    check1("sel_b_imm",  bus.sel_b_imm,  ei);
    check1("busy",       bus.busy,       eb);
    #2;
    if (fl) sb.delete();
    if (acc) begin
      lat    = (cls == 2'd1) ? MUL_N : (cls == 2'd2) ? DIV_N : 0;
      e.res  = mk(cyc + 1 + lat);
      e.vcyc = cyc + 1 + lat;
      e.op   = op;
      e.cls  = cls;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, OP_ADD, 2'd0, rdy, 1'b0);
  endtask

  task automatic check_reset_values();
    check1("rst out_valid",  bus.out_valid,  1'b0);
    check64("rst out_res",   bus.out_res,    64'h0);
    check1("rst unit_start", bus.unit_start, 1'b0);
    check1("rst sel_a_pc",   bus.sel_a_pc,   1'b0);
    check1("rst sel_b_imm",  bus.sel_b_imm,  1'b0);
    check1("rst busy",       bus.busy,       1'b0);
`ifdef EXE_SEQ_PERF_EN
    check64("rst stall_cycles", {32'h0, stall_cycles}, 64'h0);
    check64("rst op_count",     {32'h0, op_count},     64'h0);
`endif
  endtask

  // Monitor: compares presented results against the scoreboard every cycle.
  initial begin
    logic ev;
    forever begin
      @(negedge clk);
      #3;
      ev = (sb.size() != 0) && (sb[0].vcyc <= cyc);
      check1("out_valid", bus.out_valid, ev);
      if (ev) begin
        check64("out_res", bus.out_res, sb[0].res);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [1:0] cls;
    int         r;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_cls    = 2'd0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.alu_res   = 64'h0;

    repeat (3) @(negedge clk);
    #2;
    check_reset_values();
    @(negedge clk);
    #1 reset = 1'b1;

    // Single ADDI, then idle.
    drive(1'b1, OP_ADDI, 2'd0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Four back-to-back ALU ops.
    for (int i = 0; i < 4; i++) drive(1'b1, op_t'(4'(i + 9)), 2'd0, 1'b1, 1'b0);
    idle(1'b1);

    // MUL op.
    drive(1'b1, OP_MUL, 2'd1, 1'b1, 1'b0);
    repeat (5) idle(1'b1);

    // Back-pressure for five cycles, then a same-cycle accept on release.
    drive(1'b1, OP_XOR, 2'd0, 1'b0, 1'b0);
    repeat (5) drive(1'b1, OP_AND, 2'd0, 1'b0, 1'b0);
    drive(1'b1, OP_LD, 2'd0, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // DIV flushed on its tenth cycle, then a normal op.
    drive(1'b1, OP_DIV, 2'd2, 1'b1, 1'b0);
    repeat (9) idle(1'b1);
    drive(1'b0, OP_ADD, 2'd0, 1'b1, 1'b1);
    drive(1'b1, OP_AUIPC, 2'd0, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Asynchronous reset in the middle of a DIV.
    drive(1'b1, OP_DIV, 2'd2, 1'b1, 1'b0);
    repeat (4) idle(1'b1);
    @(negedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    check_reset_values();
    sb.delete();
    @(negedge clk);
    #1 reset = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      r   = $urandom_range(0, 15);
      cls = (r < 10) ? 2'd0 : (r < 12) ? 2'd3 : (r < 15) ? 2'd1 : 2'd2;
      drive($urandom_range(0, 3) != 0, op_t'(4'($urandom_range(0, 15))), cls,
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    // Drain anything still in flight.
    repeat (80) idle(1'b1);
    check1("drained", sb.size() == 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
